// File: rtl/bid_auction_n_pkg.sv
// Shared definitions for the N-bidder auction controller.
//   op_t      : host opcodes
//   ctl_err_t : host error codes reported on err
//   bid_err_t : per-bidder error codes (INVALIDREQ shares the LOWBID encoding)
//   state_t   : controller FSM states
//   RST_*     : reset values for the timer and the bid charge
package bids22defs;

  typedef enum logic [2:0] {
    OP_NOOP         = 3'd0,
    OP_UNLOCK       = 3'd1,
    OP_LOCK         = 3'd2,
    OP_LOAD         = 3'd3,
    OP_SETMASK      = 3'd4,
    OP_SETTIMER     = 3'd5,
    OP_SETBIDCHARGE = 3'd6,
    OP_INV          = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    NOERROR            = 3'd0,
    BADKEY             = 3'd1,
    ALREADYUNLOCKED    = 3'd2,
    CSTARTWHENUNLOCKED = 3'd3,
    INVALID_OP         = 3'd4
  } ctl_err_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    MASKED  = 2'd1,
    NOFUNDS = 2'd2,
    LOWBID  = 2'd3
  } bid_err_t;

  // Out-of-state requests are reported with the same 2-bit code as a low bid.
  localparam bid_err_t INVALIDREQ = LOWBID;

  typedef enum logic [2:0] {
    StUnlocked = 3'd0,
    StLocked   = 3'd1,
    StCooldown = 3'd2,
    StRound    = 3'd3,
    StSettle   = 3'd4
  } state_t;

  localparam int unsigned RST_TIMER   = 32'hF;
  localparam int unsigned RST_BIDCOST = 32'd1;

endpackage

// File: rtl/bid_auction_n_argmax.sv
// Combinational argmax over NUMBIDDERS packed values.
//   vals    : in  value i at [i*DATAWIDTH +: DATAWIDTH]
//   max_val : out largest value
//   max_idx : out index of the largest value; ties resolve to the lowest index
module bid_argmax #(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned NUMBIDDERS = 3,
  parameter int unsigned IDXW       = $clog2(NUMBIDDERS)
) (
  input  logic [NUMBIDDERS*DATAWIDTH-1:0] vals,
  output logic [DATAWIDTH-1:0]            max_val,
  output logic [IDXW-1:0]                 max_idx
);

  always_comb begin
    max_val = vals[DATAWIDTH-1:0];
    max_idx = '0;
    // Strict compare keeps the earlier (lower) index on a tie.
    for (int i = 1; i < NUMBIDDERS; i++) begin
      if (vals[i*DATAWIDTH +: DATAWIDTH] > max_val) begin
        max_val = vals[i*DATAWIDTH +: DATAWIDTH];
        max_idx = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/bid_auction_n.sv
// N-bidder sealed-round auction controller.
// Host side: lock/unlock with key, bad-key cooldown, balance load, mask, bid charge, round control.
// Bidder side: same-cycle accept/reject of bid requests; the leader is debited at round end.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   c_start               : round active while high
//   c_op, c_sel, c_data   : host opcode, bidder select for LOAD, operand
//   ready                 : controller locked and able to start a round
//   err                   : host error code for the current cycle
//   round_over            : one-cycle pulse while settling
//   max_bid, winner_idx,
//   win_valid             : result of the last round, held until the next start
//   bid, bid_amt, retract : per-bidder requests (amount i at [i*DATAWIDTH +: DATAWIDTH])
//   bid_ack, bid_err      : same-cycle per-bidder response
//   balance               : registered per-bidder balances
// Build option: define BID_RETRACT_EN to let a bidder withdraw its standing bid during a round.
module bid_auction_n
  import bids22defs::*;
#(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned NUMBIDDERS = 3,
  parameter int unsigned IDXW       = $clog2(NUMBIDDERS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            c_start,
  input  op_t                             c_op,
  input  logic [IDXW-1:0]                 c_sel,
  input  logic [DATAWIDTH-1:0]            c_data,
  output logic                            ready,
  output ctl_err_t                        err,
  output logic                            round_over,
  output logic [DATAWIDTH-1:0]            max_bid,
  output logic [IDXW-1:0]                 winner_idx,
  output logic                            win_valid,
  input  logic [NUMBIDDERS-1:0]           bid,
  input  logic [NUMBIDDERS*DATAWIDTH-1:0] bid_amt,
  input  logic [NUMBIDDERS-1:0]           retract,
  output logic [NUMBIDDERS-1:0]           bid_ack,
  output logic [NUMBIDDERS*2-1:0]         bid_err,
  output logic [NUMBIDDERS*DATAWIDTH-1:0] balance
);

  state_t                 state_q, state_d;
  logic [DATAWIDTH-1:0]   balance_q [NUMBIDDERS];
  logic [DATAWIDTH-1:0]   balance_d [NUMBIDDERS];
  logic [DATAWIDTH-1:0]   lastbid_q [NUMBIDDERS];
  logic [DATAWIDTH-1:0]   lastbid_d [NUMBIDDERS];
  logic [NUMBIDDERS-1:0]  mask_q, mask_d;
  logic [DATAWIDTH-1:0]   key_q, key_d;
  logic [DATAWIDTH-1:0]   timer_val_q, timer_val_d;
  logic [DATAWIDTH-1:0]   timer_q, timer_d;
  logic [DATAWIDTH-1:0]   bidcost_q, bidcost_d;
  logic [DATAWIDTH-1:0]   max_bid_q, max_bid_d;
  logic [IDXW-1:0]        winner_q, winner_d;
  logic                   win_valid_q, win_valid_d;

  logic [NUMBIDDERS*DATAWIDTH-1:0] lastbid_flat;
  logic [DATAWIDTH-1:0]            lead_val;
  logic [IDXW-1:0]                 lead_idx;
  logic                            sel_ok;

  for (genvar g = 0; g < NUMBIDDERS; g++) begin : g_flat
    assign balance[g*DATAWIDTH +: DATAWIDTH]      = balance_q[g];
    assign lastbid_flat[g*DATAWIDTH +: DATAWIDTH] = lastbid_q[g];
  end

  // Leader from registered standing bids; its value is the round max that new bids must beat.
  bid_argmax #(
    .DATAWIDTH (DATAWIDTH),
    .NUMBIDDERS(NUMBIDDERS),
    .IDXW      (IDXW)
  ) u_argmax (
    .vals   (lastbid_flat),
    .max_val(lead_val),
    .max_idx(lead_idx)
  );

  assign sel_ok     = (32'(c_sel) < NUMBIDDERS);
  assign ready      = (state_q == StLocked);
  assign max_bid    = max_bid_q;
  assign winner_idx = winner_q;
  assign win_valid  = win_valid_q;

  always_comb begin
    logic [DATAWIDTH-1:0] amt;
    logic [DATAWIDTH:0]   need;
    state_d     = state_q;
    balance_d   = balance_q;
    lastbid_d   = lastbid_q;
    mask_d      = mask_q;
    key_d       = key_q;
    timer_val_d = timer_val_q;
    timer_d     = timer_q;
    bidcost_d   = bidcost_q;
    max_bid_d   = max_bid_q;
    winner_d    = winner_q;
    win_valid_d = win_valid_q;
    err         = NOERROR;
    round_over  = 1'b0;
    bid_ack     = '0;
    bid_err     = '0;
    amt         = '0;
    need        = '0;

    unique case (state_q)
      StUnlocked: begin
        if (c_start) begin
          err = CSTARTWHENUNLOCKED;
        end else begin
          case (c_op)
            OP_NOOP:   ;
            OP_UNLOCK: err = ALREADYUNLOCKED;
            OP_LOCK: begin
              key_d   = c_data;
              state_d = StLocked;
            end
            OP_LOAD: begin
              if (sel_ok) balance_d[c_sel] = c_data;
              else        err = INVALID_OP;
            end
            OP_SETMASK:      mask_d      = c_data[NUMBIDDERS-1:0];
            OP_SETTIMER:     timer_val_d = c_data;
            OP_SETBIDCHARGE: bidcost_d   = c_data;
            default:         err = INVALID_OP;
          endcase
        end
      end
      StLocked: begin
        if (c_start) begin
          state_d     = StRound;
          max_bid_d   = '0;
          winner_d    = '0;
          win_valid_d = 1'b0;
          for (int i = 0; i < NUMBIDDERS; i++) lastbid_d[i] = '0;
        end else if (c_op == OP_UNLOCK) begin
          if (c_data == key_q) begin
            state_d = StUnlocked;
          end else begin
            state_d = StCooldown;
            timer_d = timer_val_q;
          end
        end else if (c_op != OP_NOOP) begin
          err = INVALID_OP;
        end
      end
      StCooldown: begin
        err = BADKEY;
        // Leave once the timer would reach zero, so a zero load still costs one cycle.
        if (timer_q <= DATAWIDTH'(1)) begin
          timer_d = '0;
          state_d = StLocked;
        end else begin
          timer_d = timer_q - DATAWIDTH'(1);
        end
      end
      StRound: begin
        if (c_op != OP_NOOP) err = INVALID_OP;
        if (!c_start) state_d = StSettle;
      end
      StSettle: begin
        round_over = 1'b1;
        state_d    = StLocked;
        if (lead_val != '0) begin
          balance_d[lead_idx] = (balance_q[lead_idx] >= lead_val) ?
                                balance_q[lead_idx] - lead_val : '0;
          max_bid_d   = lead_val;
          winner_d    = lead_idx;
          win_valid_d = 1'b1;
        end else begin
          max_bid_d   = '0;
          winner_d    = '0;
          win_valid_d = 1'b0;
        end
      end
      default: state_d = StUnlocked;
    endcase

    for (int i = 0; i < NUMBIDDERS; i++) begin
      amt  = bid_amt[i*DATAWIDTH +: DATAWIDTH];
      need = {1'b0, amt} + {1'b0, bidcost_q};
      if (state_q == StRound) begin
        if (bid[i]) begin
          if (!mask_q[i]) begin
            bid_err[2*i +: 2] = MASKED;
          end else if (need > {1'b0, balance_q[i]}) begin
            bid_err[2*i +: 2] = NOFUNDS;
          end else if (amt <= lead_val) begin
            bid_err[2*i +: 2] = LOWBID;
          end else begin
            bid_ack[i]   = 1'b1;
            balance_d[i] = balance_q[i] - bidcost_q;
            lastbid_d[i] = amt;
          end
        end else if (retract[i]) begin
`ifdef BID_RETRACT_EN
          // The bid charge already paid is kept.
          bid_ack[i]   = 1'b1;
          lastbid_d[i] = '0;
`else
          bid_err[2*i +: 2] = INVALIDREQ;
`endif
        end
      end else if (bid[i] || retract[i]) begin
        bid_err[2*i +: 2] = INVALIDREQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StUnlocked;
      for (int i = 0; i < NUMBIDDERS; i++) begin
        balance_q[i] <= '0;
        lastbid_q[i] <= '0;
      end
      mask_q      <= '1;
      key_q       <= '0;
      timer_val_q <= DATAWIDTH'(RST_TIMER);
      timer_q     <= DATAWIDTH'(RST_TIMER);
      bidcost_q   <= DATAWIDTH'(RST_BIDCOST);
      max_bid_q   <= '0;
      winner_q    <= '0;
      win_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      balance_q   <= balance_d;
      lastbid_q   <= lastbid_d;
      mask_q      <= mask_d;
      key_q       <= key_d;
      timer_val_q <= timer_val_d;
      timer_q     <= timer_d;
      bidcost_q   <= bidcost_d;
      max_bid_q   <= max_bid_d;
      winner_q    <= winner_d;
      win_valid_q <= win_valid_d;
    end
  end

endmodule
